spindash_write_sequencer: RTL and testbench

- Parametrised successor to the fixed divide-by-6 FM front end.
- Generates the FM core clock enable with a configurable divide ratio.
- Buffers host register writes (port, register, data) in a FIFO.
- Replays each write to the YM2612-compatible bus as an address strobe then a data strobe, with programmable inter-write waits. It sits between the host/CPU bridge and the FM core.

---
 rtl/spindash_write_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_spindash_write_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spindash_write_sequencer.sv
// FM clock-enable divider plus a host write FIFO replayed to a YM2612-style bus.
// Define SPINDASH_BUSY_POLL_EN to replace the fixed data wait with busy-flag polling.
module spindash_write_sequencer #(
  parameter int unsigned CEN_DIV      = 6,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned ADDR_WAIT    = 2,
  parameter int unsigned DATA_WAIT    = 17,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                            clk50,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_port,
  input  logic [7:0]                      req_reg,
  input  logic [7:0]                      req_data,
  output logic                            cen,
  output logic [7:0]                      ym_din,
  output logic [1:0]                      ym_addr,
  output logic                            ym_cs_n,
  output logic                            ym_wr_n,
  input  logic [7:0]                      ym_dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            idle,
  output logic                            busy_timeout
);
  localparam int unsigned LW       = $clog2(FIFO_DEPTH+1);
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned DW       = $clog2(CEN_DIV);
  localparam int unsigned WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int unsigned CNT_MAX  = (WAIT_MAX > BUSY_TIMEOUT) ? WAIT_MAX : BUSY_TIMEOUT;
  localparam int unsigned CW       = $clog2(CNT_MAX+1);

  logic [DW-1:0] clkdiv;

  always_ff @(posedge clk50) begin
    if (rst || clkdiv == DW'(CEN_DIV-1)) clkdiv <= '0;
    else                                 clkdiv <= clkdiv + DW'(1);
  end

  assign cen = (clkdiv == '0) && !rst;

  logic [16:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          push, pop, empty, full;
  logic          head_port;
  logic [7:0]    head_reg, head_data;

  assign empty      = (level == '0);
  assign full       = (level == LW'(FIFO_DEPTH));
  assign req_ready  = !full;
  assign push       = req_valid && req_ready;
  assign fifo_level = level;
  assign {head_port, head_reg, head_data} = mem[rd_ptr];

  always_ff @(posedge clk50) begin
    if (push) mem[wr_ptr] <= {req_port, req_reg, req_data};
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  typedef enum logic [2:0] {S_IDLE, S_ASTB, S_AWAIT, S_DSTB, S_DWAIT, S_POLL} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          cur_port, cur_port_nx;
  logic [7:0]    cur_data, cur_data_nx;
  logic [1:0]    addr_q, addr_nx;
  logic [7:0]    din_q, din_nx;
  logic          cs_q, cs_nx, wr_q, wr_nx, bto_q, bto_nx;
  logic          done;

  always_ff @(posedge clk50) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_port <= 1'b0;
      cur_data <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      cs_q     <= 1'b1;
      wr_q     <= 1'b1;
      bto_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cur_port <= cur_port_nx;
      cur_data <= cur_data_nx;
      addr_q   <= addr_nx;
      din_q    <= din_nx;
      cs_q     <= cs_nx;
      wr_q     <= wr_nx;
      bto_q    <= bto_nx;
    end
  end

  // IDLE, the end of the data wait and the end of polling all share the
  // "start next entry or go idle" decision carried by done.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    cur_port_nx = cur_port;
    cur_data_nx = cur_data;
    addr_nx     = addr_q;
    din_nx      = din_q;
    cs_nx       = cs_q;
    wr_nx       = wr_q;
    bto_nx      = bto_q;
    pop         = 1'b0;
    done        = 1'b0;
    if (cen) begin
      unique case (state)
        S_IDLE: done = 1'b1;
        S_ASTB: begin
          cs_nx    = 1'b1;
          wr_nx    = 1'b1;
          state_nx = S_AWAIT;
          cnt_nx   = CW'(ADDR_WAIT);
        end
        S_AWAIT: begin
          if (cnt == CW'(1)) begin
            state_nx = S_DSTB;
            addr_nx  = {cur_port, 1'b1};
            din_nx   = cur_data;
            cs_nx    = 1'b0;
            wr_nx    = 1'b0;
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
        S_DSTB: begin
          cs_nx    = 1'b1;
          wr_nx    = 1'b1;
          state_nx = S_DWAIT;
`ifdef SPINDASH_BUSY_POLL_EN
          cnt_nx   = CW'(1);
`else
          cnt_nx   = CW'(DATA_WAIT);
`endif
        end
        S_DWAIT: begin
          if (cnt == CW'(1)) begin
`ifdef SPINDASH_BUSY_POLL_EN
            state_nx = S_POLL;
            cnt_nx   = CW'(1);
            addr_nx  = {cur_port, 1'b0};
            cs_nx    = 1'b0;
            wr_nx    = 1'b1;
`else
            done     = 1'b1;
`endif
          end else begin
            cnt_nx = cnt - CW'(1);
          end
        end
`ifdef SPINDASH_BUSY_POLL_EN
        S_POLL: begin
          if (!ym_dout[7] || cnt == CW'(BUSY_TIMEOUT)) begin
            bto_nx = bto_q | ym_dout[7];
            done   = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
`endif
        default: state_nx = S_IDLE;
      endcase
      if (done) begin
        if (!empty) begin
          pop         = 1'b1;
          state_nx    = S_ASTB;
          cur_port_nx = head_port;
          cur_data_nx = head_data;
          addr_nx     = {head_port, 1'b0};
          din_nx      = head_reg;
          cs_nx       = 1'b0;
          wr_nx       = 1'b0;
        end else begin
          state_nx = S_IDLE;
          cs_nx    = 1'b1;
          wr_nx    = 1'b1;
        end
      end
    end
  end

`ifndef SPINDASH_BUSY_POLL_EN
  logic unused_dout;
  assign unused_dout = ^ym_dout;
`endif

  assign ym_addr      = addr_q;
  assign ym_din       = din_q;
  assign ym_cs_n      = cs_q;
  assign ym_wr_n      = wr_q;
  assign busy_timeout = bto_q;
  assign idle         = empty && (state == S_IDLE);

endmodule

// File: tb/tb_spindash_write_sequencer.sv
// Bench for spindash_write_sequencer: a schedule-level model predicts every bus
// cycle from the write queue; directed phases pin strobe timing with literals.
module tb_spindash_write_sequencer;
  localparam int CEN_DIV      = 6;
  localparam int FIFO_DEPTH   = 16;
  localparam int ADDR_WAIT    = 2;
  localparam int DATA_WAIT    = 17;
  localparam int BUSY_TIMEOUT = 64;
  localparam int LW           = $clog2(FIFO_DEPTH+1);
  localparam int WR_CENS      = 2 + ADDR_WAIT + DATA_WAIT;
  localparam int PERIOD       = CEN_DIV * WR_CENS;
  localparam int DSTB_OFS     = CEN_DIV * (1 + ADDR_WAIT);

  logic          clk50 = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_port = 1'b0;
  logic [7:0]    req_reg = '0;
  logic [7:0]    req_data = '0;
  logic [7:0]    ym_dout = '0;
  logic          req_ready, cen, ym_cs_n, ym_wr_n, idle, busy_timeout;
  logic [7:0]    ym_din;
  logic [1:0]    ym_addr;
  logic [LW-1:0] fifo_level;

  spindash_write_sequencer #(
    .CEN_DIV(CEN_DIV), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WAIT(ADDR_WAIT),
    .DATA_WAIT(DATA_WAIT), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk50(clk50), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_port(req_port), .req_reg(req_reg), .req_data(req_data), .cen(cen),
    .ym_din(ym_din), .ym_addr(ym_addr), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
    .ym_dout(ym_dout), .fifo_level(fifo_level), .idle(idle), .busy_timeout(busy_timeout)
  );

  always #10 clk50 = ~clk50;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic port; logic [7:0] rg; logic [7:0] dt; } ent_t;
  typedef struct { int k; ent_t e; } wr_t;

  ent_t pend[$];
  wr_t  wq[$];
  ent_t e_tmp;
  wr_t  w_tmp;
  int   cyc, free_at, base, m_level;
  logic [1:0] m_addr;
  logic [7:0] m_din;
  logic m_low, rst_prev = 1'b0, prev_wr = 1'b1, prev_idle = 1'b1;

  int fall_cyc[$];
  int fall_info[$];
  int rise_cyc[$];
  int idle_rise, cen_cnt, max_lvl;

  function automatic void clear_logs();
    fall_cyc.delete();
    fall_info.delete();
    rise_cyc.delete();
    idle_rise = -1;
    cen_cnt   = 0;
    max_lvl   = 0;
  endfunction

  function automatic int fc(input int i);
    return (i < fall_cyc.size()) ? fall_cyc[i] : -100000;
  endfunction
  function automatic int fa(input int i);
    return (i < fall_info.size()) ? (fall_info[i] >> 8) : -1;
  endfunction
  function automatic int fd(input int i);
    return (i < fall_info.size()) ? (fall_info[i] & 255) : -1;
  endfunction

  always @(negedge clk50) begin
    if (rst) begin
      check("cen_in_rst", int'(cen), 0);
      if (rst_prev) begin
        check("rst_cs_n", int'(ym_cs_n), 1);
        check("rst_wr_n", int'(ym_wr_n), 1);
        check("rst_addr", int'(ym_addr), 0);
        check("rst_din", int'(ym_din), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_ready", int'(req_ready), 1);
        check("rst_idle", int'(idle), 1);
        check("rst_bto", int'(busy_timeout), 0);
      end
      rst_prev = 1'b1;
      pend.delete();
      wq.delete();
      cyc = 0; free_at = 0; m_addr = '0; m_din = '0;
      prev_wr = 1'b1; prev_idle = 1'b1;
      clear_logs();
    end else begin
      rst_prev = 1'b0;
      if (wq.size() > 0 && cyc > wq[0].k * CEN_DIV + PERIOD) void'(wq.pop_front());
      m_low = 1'b0;
      if (wq.size() > 0) begin
        base = wq[0].k * CEN_DIV;
        if (cyc == base + 1) begin
          m_addr = {wq[0].e.port, 1'b0};
          m_din  = wq[0].e.rg;
        end
        if (cyc == base + DSTB_OFS + 1) begin
          m_addr = {wq[0].e.port, 1'b1};
          m_din  = wq[0].e.dt;
        end
        m_low = (cyc >= base + 1 && cyc <= base + CEN_DIV) ||
                (cyc >= base + DSTB_OFS + 1 && cyc <= base + DSTB_OFS + CEN_DIV);
      end
      m_level = pend.size();
      check("cen", int'(cen), int'(cyc % CEN_DIV == 0));
      check("wr_n", int'(ym_wr_n), int'(!m_low));
      check("cs_n", int'(ym_cs_n), int'(!m_low));
      check("addr", int'(ym_addr), int'(m_addr));
      check("din", int'(ym_din), int'(m_din));
      check("level", int'(fifo_level), m_level);
      check("ready", int'(req_ready), int'(m_level < FIFO_DEPTH));
      check("idle", int'(idle), int'(m_level == 0 && wq.size() == 0));
      check("bto", int'(busy_timeout), 0);
      // a write starts on the first cen that both has an entry queued and is past the previous write
      if (cyc % CEN_DIV == 0 && cyc / CEN_DIV >= free_at && pend.size() > 0) begin
        w_tmp.k = cyc / CEN_DIV;
        w_tmp.e = pend.pop_front();
        wq.push_back(w_tmp);
        free_at = w_tmp.k + WR_CENS;
      end
      if (req_valid && m_level < FIFO_DEPTH) begin
        e_tmp.port = req_port;
        e_tmp.rg   = req_reg;
        e_tmp.dt   = req_data;
        pend.push_back(e_tmp);
      end
      if (!ym_wr_n && prev_wr) begin
        fall_cyc.push_back(cyc);
        fall_info.push_back(int'({ym_addr, ym_din}));
      end
      if (ym_wr_n && !prev_wr) rise_cyc.push_back(cyc);
      if (idle && !prev_idle) idle_rise = cyc;
      if (cen) cen_cnt++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      prev_wr   = ym_wr_n;
      prev_idle = idle;
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic push1(input logic p, input logic [7:0] r, input logic [7:0] d);
    req_valid = 1'b1; req_port = p; req_reg = r; req_data = d;
    step();
    req_valid = 1'b0;
  endtask

  int acc;
  int prob;
  logic found;

  initial begin
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    repeat (60) step();
    check("t1_cen_count", cen_cnt, 10);
    check("t1_no_strobe", fall_cyc.size(), 0);
    check("t1_ready", int'(req_ready), 1);
    check("t1_idle", int'(idle), 1);

    clear_logs();
    push1(1'b0, 8'h28, 8'hF0);
    repeat (140) step();
    check("t2_strobes", fall_cyc.size(), 2);
    check("t2_a_addr", fa(0), 0);
    check("t2_a_din", fd(0), 8'h28);
    check("t2_a_width", (rise_cyc.size() > 0) ? rise_cyc[0] - fc(0) : -1, 6);
    check("t2_d_delay", fc(1) - fc(0), 18);
    check("t2_d_addr", fa(1), 1);
    check("t2_d_din", fd(1), 8'hF0);
    check("t2_idle_after", idle_rise - fc(0), 126);

    clear_logs();
    req_valid = 1'b1; req_port = 1'b1; req_reg = 8'hA4; req_data = 8'h22;
    step();
    req_port = 1'b0; req_reg = 8'h30; req_data = 8'h71;
    step();
    req_valid = 1'b0;
    repeat (280) step();
    check("t3_strobes", fall_cyc.size(), 4);
    check("t3_b2b_period", fc(2) - fc(0), 126);
    check("t3_d1_addr", fa(1), 3);
    check("t3_d1_din", fd(1), 8'h22);
    check("t3_a2_addr", fa(2), 0);
    check("t3_a2_din", fd(2), 8'h30);
    check("t3_d2_din", fd(3), 8'h71);

    clear_logs();
    push1(1'b1, 8'h01, 8'h02);
    repeat (10) step();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      req_valid = 1'b1;
      req_port  = 1'($urandom_range(0, 1));
      req_reg   = 8'($urandom);
      req_data  = 8'($urandom);
      @(negedge clk50);
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    check("t4_accepted", acc, 16);
    check("t4_full_ready", int'(req_ready), 0);
    check("t4_full_level", int'(fifo_level), 16);
    for (int i = 0; i < 3000 && !idle; i++) step();
    check("t4_drained", int'(idle), 1);
    check("t4_max_level", max_lvl, 16);

    clear_logs();
    for (int i = 0; i < 3; i++) push1(1'(i), 8'(8'h40 + i), 8'(8'h90 + i));
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk50);
      if (!ym_wr_n && ym_addr[0]) found = 1'b1;
    end
    check("t5_reach_dstb", int'(found), 1);
    step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("t5_level_after_rst", int'(fifo_level), 0);
    repeat (300) step();
    check("t5_no_strobe", fall_cyc.size(), 0);

    for (int n = 0; n < 6000; n++) begin
      prob = (n < 2500) ? 1 : (n < 4500) ? 30 : 0;
      rst = (n == 3500 || n == 3501);
      req_valid = !rst && (int'($urandom_range(0, 99)) < prob);
      req_port  = 1'($urandom_range(0, 1));
      req_reg   = 8'($urandom);
      req_data  = 8'($urandom);
      ym_dout   = 8'($urandom);
      step();
    end
    req_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) step();
    check("t6_drained", int'(idle), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
